sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's fixed 8x8 FIFO.
- Adds configurable width and depth, a fill-level output, programmable almost-full and almost-empty flags, and overflow/underflow error pulses.
- Adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- DEPTH, 16, number of entries. Must be a power of two and at least 4; elaboration error otherwise.
- ADDR_WIDTH, $clog2(DEPTH), memory address width. Derived value; do not override.
- ALMOST_FULL_TH, DEPTH-2, sig_Almost_Full asserts when fill_Count >= this value. Legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2, sig_Almost_Empty asserts when fill_Count <= this value. Legal range 0..DEPTH-1.
- FWFT, 0, read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- write_Enable  in  1  write request.
- buffer_Input  in  DATA_WIDTH  write data.
- read_Enable  in  1  read request (standard mode) or pop (FWFT mode).
- buffer_Output  out  DATA_WIDTH  read data.
- valid_Output  out  1  buffer_Output holds valid data.
- sig_Full  out  1  fill_Count == DEPTH.
- sig_Empty  out  1  fill_Count == 0.
- sig_Almost_Full  out  1  fill_Count >= ALMOST_FULL_TH.
- sig_Almost_Empty  out  1  fill_Count <= ALMOST_EMPTY_TH.
- fill_Count  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (asynchronous, active-high):
  - Read and write pointers = 0, fill_Count = 0.
  - sig_Empty = 1, sig_Almost_Empty = 1.
  - sig_Full = 0, sig_Almost_Full = 0 (the threshold is >= 1).
  - buffer_Output = 0, valid_Output = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits wide. The low bits address memory; the MSB is a wrap bit.
- Pointers wrap modulo 2*DEPTH. There is no special case at the DEPTH-1 to 0 boundary.
- All flags decode combinationally from the registered fill_Count, so they are valid in the cycle after the causing edge.
- Write accept condition: write_Enable && (!sig_Full || read accepted in the same cycle).
  - Data is written at wr_ptr; wr_ptr increments.
  - A rejected write changes no state and pulses overflow for one cycle.
- Read accept condition: read_Enable && !sig_Empty.
  - rd_ptr increments.
  - A rejected read changes no state and pulses underflow for one cycle.
- Simultaneous write and read:
  - When full: both are accepted; fill_Count stays at DEPTH.
  - When empty: the write is accepted, the read is rejected, underflow pulses, and fill_Count becomes 1.
  - Otherwise: both are accepted; fill_Count is unchanged.
- fill_Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Standard mode (FWFT=0):
  - buffer_Output registers mem[rd_ptr] on an accepted read; read latency is 1 cycle.
  - valid_Output = 1 in the cycle after an accepted read, otherwise 0.
  - buffer_Output holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - buffer_Output shows the head entry whenever fill_Count > 0.
  - valid_Output = !sig_Empty.
  - read_Enable pops the head entry; the next entry is visible in the following cycle.
  - A word written into an empty FIFO is visible on buffer_Output 1 cycle after the write edge.
- flush:
  - Pointers, fill_Count, valid_Output, overflow and underflow return to their reset values on the next edge.
  - flush has priority over write and read in the same cycle; neither is accepted and no error pulse is generated.
- Reset asserted mid-operation: all state clears immediately. Data in flight is lost and no error pulse is generated.

Decomposition:
- Package fifo_pkg holds:
  - default constants: DEF_DATA_WIDTH = 8, DEF_DEPTH = 16;
  - the read-mode encodings MODE_STD = 0 and MODE_FWFT = 1.
- One sub-module, fifo_mem_dp: simple dual-port register array.
  - Synchronous write port, asynchronous read port, parameters DATA_WIDTH and DEPTH.
- Pointer logic, count logic, flag logic and output logic live in the top level.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with no reads (default parameters) -> sig_Full = 1 and fill_Count = 16; sig_Almost_Full first asserts after the 14th write; a 17th write pulses overflow and leaves fill_Count at 16.
- Drain all 16 entries in standard mode -> data 0x00..0x0F in order, each 1 cycle after its read_Enable; sig_Empty = 1 after the last read; one extra read pulses underflow and valid_Output stays 0.
- FWFT=1: write 0xA5 into an empty FIFO -> buffer_Output = 0xA5 and valid_Output = 1 the next cycle with no read; pop -> valid_Output = 0.
- Full FIFO, simultaneous write 0x77 and read -> head word read, fill_Count stays 16, no overflow; 0x77 emerges as the 16th subsequent read.
- Empty FIFO, simultaneous write 0x3C and read -> underflow pulses, fill_Count = 1, the next read returns 0x3C.
- Write 5 entries, assert flush together with write_Enable -> fill_Count = 0, sig_Empty = 1, no overflow; then assert reset mid-write with 3 entries stored -> all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO.
//   DEF_DATA_WIDTH / DEF_DEPTH : default geometry
//   MODE_STD / MODE_FWFT       : read-mode encodings for the FWFT parameter
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, programmable almost flags,
// overflow/underflow pulses, synchronous flush and optional FWFT read mode.
//   clock, reset     : clock and asynchronous active-high reset
//   flush            : synchronous clear of pointers/count/status
//   write_Enable,
//   buffer_Input     : write request and data
//   read_Enable      : read request (standard) or pop (FWFT)
//   buffer_Output,
//   valid_Output     : read data and its qualifier
//   sig_Full, sig_Empty, sig_Almost_Full, sig_Almost_Empty : status flags
//   fill_Count       : stored entries, 0..DEPTH
//   overflow, underflow : one-cycle pulses for rejected write / read
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int ADDR_WIDTH      = $clog2(DEPTH),
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = MODE_STD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write_Enable,
    input  logic [DATA_WIDTH-1:0] buffer_Input,
    input  logic                  read_Enable,
    output logic [DATA_WIDTH-1:0] buffer_Output,
    output logic                  valid_Output,
    output logic                  sig_Full,
    output logic                  sig_Empty,
    output logic                  sig_Almost_Full,
    output logic                  sig_Almost_Empty,
    output logic [ADDR_WIDTH:0]   fill_Count,
    output logic                  overflow,
    output logic                  underflow
);

    // Elaboration-time parameter checks.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr
        $error("sync_fifo_param: ADDR_WIDTH must equal $clog2(DEPTH)");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: ALMOST_FULL_TH out of range");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: ALMOST_EMPTY_TH out of range");
    end
    if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    localparam logic [ADDR_WIDTH:0] FullCnt = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AfTh    = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeTh    = ALMOST_EMPTY_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] One     = 1;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full, empty;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] head;

    // Wrap bits are kept for pointer bookkeeping; occupancy comes from count_q.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr_q[ADDR_WIDTH] ^ rd_ptr_q[ADDR_WIDTH];

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (buffer_Input),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (head)
    );

    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == FullCnt);
        rd_acc = read_Enable && !empty && !flush;
        // A full FIFO can still take a write when a read frees a slot this cycle.
        wr_acc = write_Enable && (!full || rd_acc) && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + One;
            if (rd_acc) rd_ptr_d = rd_ptr_q + One;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + One;
                2'b01:   count_d = count_q - One;
                default: count_d = count_q;
            endcase
        end

        // Flush suppresses both requests without flagging an error.
        ovf_d = write_Enable && !wr_acc && !flush;
        udf_d = read_Enable && !rd_acc && !flush;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign fill_Count       = count_q;
    assign sig_Full         = full;
    assign sig_Empty        = empty;
    assign sig_Almost_Full  = (count_q >= AfTh);
    assign sig_Almost_Empty = (count_q <= AeTh);
    assign overflow         = ovf_q;
    assign underflow        = udf_q;

    if (FWFT == MODE_FWFT) begin : g_fwft
        // Head of queue is shown directly; zero while empty so reset reads as 0.
        assign buffer_Output = empty ? '0 : head;
        assign valid_Output  = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                if (rd_acc) dout_q <= head;
                valid_q <= rd_acc;
            end
        end

        assign buffer_Output = dout_q;
        assign valid_Output  = valid_q;
    end

endmodule
